// File: rtl/cordic_pkg.sv
// Shared definitions for the CORDIC request arbiter.
package cordic_pkg;

   localparam int unsigned N_FRAC_DEF         = 7;
   localparam int unsigned TIMEOUT_CYCLES_DEF = 15;
   localparam int unsigned ITERATIONS         = 6;

   // Arbiter FSM encoding; the unused patterns do not exist in a 2-bit space,
   // but the FSM still carries a default arm back to idle.
   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ISSUE   = 2'd1,
      ST_WAIT    = 2'd2,
      ST_DELIVER = 2'd3
   } state_e;

   // Width of a counter that must reach max_val without wrapping.
   function automatic int unsigned cnt_width(input int unsigned max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

   // Number of micro-rotations the shared CORDIC core performs per job.
   function automatic int unsigned cordic_iterations();
      return ITERATIONS;
   endfunction

endpackage

// File: rtl/cordic_req_slot.sv
// One-entry operand buffer with a busy flag; strobes while busy are dropped.
module cordic_req_slot #(
   parameter int unsigned W = 8
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                strobe_i,
   input  logic                clr_i,
   input  logic signed [W-1:0] x_i,
   input  logic signed [W-1:0] y_i,
   input  logic signed [W-1:0] z_i,
   output logic                busy_o,
   output logic signed [W-1:0] x_o,
   output logic signed [W-1:0] y_o,
   output logic signed [W-1:0] z_o
);

   logic                busy_q, busy_d;
   logic signed [W-1:0] x_q, x_d;
   logic signed [W-1:0] y_q, y_d;
   logic signed [W-1:0] z_q, z_d;

   // Load on a strobe only when empty; clear is only ever issued while full.
   always_comb begin
      busy_d = busy_q;
      x_d    = x_q;
      y_d    = y_q;
      z_d    = z_q;
      if (clr_i) begin
         busy_d = 1'b0;
      end
      if (strobe_i && !busy_q) begin
         busy_d = 1'b1;
         x_d    = x_i;
         y_d    = y_i;
         z_d    = z_i;
      end
   end

   // Slot registers with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         busy_q <= 1'b0;
         x_q    <= '0;
         y_q    <= '0;
         z_q    <= '0;
      end else begin
         busy_q <= busy_d;
         x_q    <= x_d;
         y_q    <= y_d;
         z_q    <= z_d;
      end
   end

   assign busy_o = busy_q;
   assign x_o    = x_q;
   assign y_o    = y_q;
   assign z_o    = z_q;

endmodule

// File: rtl/cordic_arbiter.sv
// Two-channel round-robin arbiter in front of a single shared CORDIC core.
module cordic_arbiter
   import cordic_pkg::*;
#(
   parameter int unsigned N_FRAC         = N_FRAC_DEF,
   parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 req0_valid_strobe_i,
   input  logic signed [N_FRAC:0] req0_x_i,
   input  logic signed [N_FRAC:0] req0_y_i,
   input  logic signed [N_FRAC:0] req0_z_i,
   input  logic                 req1_valid_strobe_i,
   input  logic signed [N_FRAC:0] req1_x_i,
   input  logic signed [N_FRAC:0] req1_y_i,
   input  logic signed [N_FRAC:0] req1_z_i,
   output logic                 req0_busy_o,
   output logic                 req1_busy_o,
   output logic signed [N_FRAC:0] cordic_x_o,
   output logic signed [N_FRAC:0] cordic_y_o,
   output logic signed [N_FRAC:0] cordic_z_o,
   output logic                 cordic_valid_strobe_o,
   input  logic signed [N_FRAC:0] cordic_x_i,
   input  logic signed [N_FRAC:0] cordic_y_i,
   input  logic signed [N_FRAC:0] cordic_z_i,
   input  logic                 cordic_valid_strobe_i,
   output logic signed [N_FRAC:0] res_x_o,
   output logic signed [N_FRAC:0] res_y_o,
   output logic signed [N_FRAC:0] res_z_o,
   output logic                 res0_valid_strobe_o,
   output logic                 res1_valid_strobe_o,
   output logic                 timeout_o
);

   localparam int unsigned W     = N_FRAC + 1;
   localparam int unsigned CNT_W = cnt_width(TIMEOUT_CYCLES);

   logic                slot0_busy_c, slot1_busy_c;
   logic                clr0_c, clr1_c;
   logic signed [W-1:0] s0_x_c, s0_y_c, s0_z_c;
   logic signed [W-1:0] s1_x_c, s1_y_c, s1_z_c;

   state_e              state_q, state_d;
   logic                grant_q, grant_d;
   logic                last_grant_q, last_grant_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                cordic_valid_q, cordic_valid_d;
   logic signed [W-1:0] cordic_x_q, cordic_x_d;
   logic signed [W-1:0] cordic_y_q, cordic_y_d;
   logic signed [W-1:0] cordic_z_q, cordic_z_d;
   logic signed [W-1:0] res_x_q, res_x_d;
   logic signed [W-1:0] res_y_q, res_y_d;
   logic signed [W-1:0] res_z_q, res_z_d;
   logic                res0_valid_q, res0_valid_d;
   logic                res1_valid_q, res1_valid_d;
   logic                timeout_q, timeout_d;

   cordic_req_slot #(.W(W)) u_slot0 (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .strobe_i (req0_valid_strobe_i),
      .clr_i    (clr0_c),
      .x_i      (req0_x_i),
      .y_i      (req0_y_i),
      .z_i      (req0_z_i),
      .busy_o   (slot0_busy_c),
      .x_o      (s0_x_c),
      .y_o      (s0_y_c),
      .z_o      (s0_z_c)
   );

   cordic_req_slot #(.W(W)) u_slot1 (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .strobe_i (req1_valid_strobe_i),
      .clr_i    (clr1_c),
      .x_i      (req1_x_i),
      .y_i      (req1_y_i),
      .z_i      (req1_z_i),
      .busy_o   (slot1_busy_c),
      .x_o      (s1_x_c),
      .y_o      (s1_y_c),
      .z_o      (s1_z_c)
   );

   // Next-state and registered-output logic; strobes are set on entry to a state.
   always_comb begin
      state_d        = state_q;
      grant_d        = grant_q;
      last_grant_d   = last_grant_q;
      cnt_d          = cnt_q;
      cordic_valid_d = 1'b0;
      cordic_x_d     = cordic_x_q;
      cordic_y_d     = cordic_y_q;
      cordic_z_d     = cordic_z_q;
      res_x_d        = res_x_q;
      res_y_d        = res_y_q;
      res_z_d        = res_z_q;
      res0_valid_d   = 1'b0;
      res1_valid_d   = 1'b0;
      timeout_d      = 1'b0;
      clr0_c         = 1'b0;
      clr1_c         = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (slot0_busy_c || slot1_busy_c) begin
               // Round-robin only matters when both slots compete.
               grant_d        = (slot0_busy_c && slot1_busy_c) ? ~last_grant_q : slot1_busy_c;
               state_d        = ST_ISSUE;
               cordic_valid_d = 1'b1;
               cordic_x_d     = grant_d ? s1_x_c : s0_x_c;
               cordic_y_d     = grant_d ? s1_y_c : s0_y_c;
               cordic_z_d     = grant_d ? s1_z_c : s0_z_c;
            end
         end
         ST_ISSUE: begin
            state_d = ST_WAIT;
            cnt_d   = '0;
         end
         ST_WAIT: begin
            if (cordic_valid_strobe_i) begin
               // A done strobe beats a simultaneous timeout.
               state_d      = ST_DELIVER;
               res_x_d      = cordic_x_i;
               res_y_d      = cordic_y_i;
               res_z_d      = cordic_z_i;
               res0_valid_d = ~grant_q;
               res1_valid_d = grant_q;
            end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES)) begin
               state_d      = ST_IDLE;
               timeout_d    = 1'b1;
               last_grant_d = grant_q;
               clr0_c       = ~grant_q;
               clr1_c       = grant_q;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_DELIVER: begin
            state_d      = ST_IDLE;
            last_grant_d = grant_q;
            clr0_c       = ~grant_q;
            clr1_c       = grant_q;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q        <= ST_IDLE;
         grant_q        <= 1'b0;
         last_grant_q   <= 1'b1;
         cnt_q          <= '0;
         cordic_valid_q <= 1'b0;
         cordic_x_q     <= '0;
         cordic_y_q     <= '0;
         cordic_z_q     <= '0;
         res_x_q        <= '0;
         res_y_q        <= '0;
         res_z_q        <= '0;
         res0_valid_q   <= 1'b0;
         res1_valid_q   <= 1'b0;
         timeout_q      <= 1'b0;
      end else begin
         state_q        <= state_d;
         grant_q        <= grant_d;
         last_grant_q   <= last_grant_d;
         cnt_q          <= cnt_d;
         cordic_valid_q <= cordic_valid_d;
         cordic_x_q     <= cordic_x_d;
         cordic_y_q     <= cordic_y_d;
         cordic_z_q     <= cordic_z_d;
         res_x_q        <= res_x_d;
         res_y_q        <= res_y_d;
         res_z_q        <= res_z_d;
         res0_valid_q   <= res0_valid_d;
         res1_valid_q   <= res1_valid_d;
         timeout_q      <= timeout_d;
      end
   end

   assign req0_busy_o           = slot0_busy_c;
   assign req1_busy_o           = slot1_busy_c;
   assign cordic_valid_strobe_o = cordic_valid_q;
   assign cordic_x_o            = cordic_x_q;
   assign cordic_y_o            = cordic_y_q;
   assign cordic_z_o            = cordic_z_q;
   assign res_x_o               = res_x_q;
   assign res_y_o               = res_y_q;
   assign res_z_o               = res_z_q;
   assign res0_valid_strobe_o   = res0_valid_q;
   assign res1_valid_strobe_o   = res1_valid_q;
   assign timeout_o             = timeout_q;

endmodule

// File: tb/tb_cordic_arbiter.sv
// Directed bench for cordic_arbiter with a fixed-latency CORDIC model.
module tb_cordic_arbiter;

   localparam int unsigned W = 8;
   localparam int unsigned T = 15;

   logic clk = 1'b0;
   logic rst;
   logic req0_valid_strobe_i, req1_valid_strobe_i;
   logic signed [W-1:0] req0_x_i, req0_y_i, req0_z_i;
   logic signed [W-1:0] req1_x_i, req1_y_i, req1_z_i;
   logic req0_busy_o, req1_busy_o;
   logic signed [W-1:0] cordic_x_o, cordic_y_o, cordic_z_o;
   logic cordic_valid_strobe_o;
   logic signed [W-1:0] cordic_x_i, cordic_y_i, cordic_z_i;
   logic cordic_valid_strobe_i;
   logic signed [W-1:0] res_x_o, res_y_o, res_z_o;
   logic res0_valid_strobe_o, res1_valid_strobe_o, timeout_o;

   cordic_arbiter #(.N_FRAC(7), .TIMEOUT_CYCLES(T)) dut (
      .clk_i                 (clk),
      .rst_i                 (rst),
      .req0_valid_strobe_i   (req0_valid_strobe_i),
      .req0_x_i              (req0_x_i),
      .req0_y_i              (req0_y_i),
      .req0_z_i              (req0_z_i),
      .req1_valid_strobe_i   (req1_valid_strobe_i),
      .req1_x_i              (req1_x_i),
      .req1_y_i              (req1_y_i),
      .req1_z_i              (req1_z_i),
      .req0_busy_o           (req0_busy_o),
      .req1_busy_o           (req1_busy_o),
      .cordic_x_o            (cordic_x_o),
      .cordic_y_o            (cordic_y_o),
      .cordic_z_o            (cordic_z_o),
      .cordic_valid_strobe_o (cordic_valid_strobe_o),
      .cordic_x_i            (cordic_x_i),
      .cordic_y_i            (cordic_y_i),
      .cordic_z_i            (cordic_z_i),
      .cordic_valid_strobe_i (cordic_valid_strobe_i),
      .res_x_o               (res_x_o),
      .res_y_o               (res_y_o),
      .res_z_o               (res_z_o),
      .res0_valid_strobe_o   (res0_valid_strobe_o),
      .res1_valid_strobe_o   (res1_valid_strobe_o),
      .timeout_o             (timeout_o)
   );

   always #5 clk = ~clk;

   logic [53:0] all_out;
   assign all_out = {req0_busy_o, req1_busy_o, cordic_x_o, cordic_y_o, cordic_z_o,
                     cordic_valid_strobe_o, res_x_o, res_y_o, res_z_o,
                     res0_valid_strobe_o, res1_valid_strobe_o, timeout_o};

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // CORDIC model: done model_lat cycles after a start strobe, results = operands + 1.
   bit model_en = 1'b1;
   int model_lat = 7;
   int m_cnt = 0;
   logic signed [W-1:0] m_x, m_y, m_z;
   always @(negedge clk) begin
      cordic_valid_strobe_i = 1'b0;
      if (m_cnt > 0) begin
         m_cnt--;
         if (m_cnt == 0) begin
            cordic_x_i = m_x + 8'sd1;
            cordic_y_i = m_y + 8'sd1;
            cordic_z_i = m_z + 8'sd1;
            cordic_valid_strobe_i = 1'b1;
         end
      end
      if (cordic_valid_strobe_o && model_en) begin
         m_x = cordic_x_o;
         m_y = cordic_y_o;
         m_z = cordic_z_o;
         m_cnt = model_lat;
      end
   end

   // Strobe counters; values sampled are those held during the cycle just ending.
   int n_cordic = 0, n_res0 = 0, n_res1 = 0, n_to = 0;
   always @(posedge clk) begin
      if (cordic_valid_strobe_o) n_cordic++;
      if (res0_valid_strobe_o)   n_res0++;
      if (res1_valid_strobe_o)   n_res1++;
      if (timeout_o)             n_to++;
   end

   function automatic logic sel_sig(input int sel);
      case (sel)
         0:       return cordic_valid_strobe_o;
         1:       return res0_valid_strobe_o;
         2:       return res1_valid_strobe_o;
         default: return timeout_o;
      endcase
   endfunction

   // Returns the number of negedges until the selected strobe is seen, -1 if never.
   task automatic wait_for(input int sel, input int budget, output int cyc);
      cyc = -1;
      for (int i = 1; i <= budget; i++) begin
         @(negedge clk);
         if (sel_sig(sel)) begin
            cyc = i;
            break;
         end
      end
   endtask

   task automatic set_ch(input bit ch, input logic signed [W-1:0] x, y, z);
      if (!ch) begin
         req0_valid_strobe_i = 1'b1; req0_x_i = x; req0_y_i = y; req0_z_i = z;
      end else begin
         req1_valid_strobe_i = 1'b1; req1_x_i = x; req1_y_i = y; req1_z_i = z;
      end
   endtask

   task automatic pulse();
      @(negedge clk);
      req0_valid_strobe_i = 1'b0;
      req1_valid_strobe_i = 1'b0;
   endtask

   // Wait for the next issue and its delivery on channel ch.
   task automatic serve(input string tag, input logic signed [W-1:0] ex, input bit ch);
      int k;
      logic signed [W-1:0] er;
      er = ex + 8'sd1;
      wait_for(0, 40, k);
      check({tag, "_issue"}, 64'(k > 0), 64'd1);
      check({tag, "_op"}, 64'(cordic_x_o), 64'(ex));
      wait_for(ch ? 2 : 1, 20, k);
      check({tag, "_res_lat"}, 64'(k), 64'd8);
      check({tag, "_res_x"}, 64'(res_x_o), 64'(er));
   endtask

   typedef struct {
      bit ch;
      logic signed [W-1:0] x, y, z, ex, ey, ez;
   } vec_t;

   vec_t vecs[4];

   initial begin
      int k, c0, r0, r1, t0;
      vecs[0] = '{ch: 1'b0, x:  8'sd10,  y:  8'sd0,    z:  8'sd32, ex:  8'sd11,  ey:  8'sd1,    ez:  8'sd33};
      vecs[1] = '{ch: 1'b1, x: -8'sd5,   y:  8'sd20,   z: -8'sd64, ex: -8'sd4,   ey:  8'sd21,   ez: -8'sd63};
      vecs[2] = '{ch: 1'b0, x:  8'sd127, y: -8'sd128,  z:  8'sd0,  ex: -8'sd128, ey: -8'sd127,  ez:  8'sd1};
      vecs[3] = '{ch: 1'b1, x: -8'sd1,   y: -8'sd1,    z: -8'sd1,  ex:  8'sd0,   ey:  8'sd0,    ez:  8'sd0};

      rst = 1'b1;
      req0_valid_strobe_i = 1'b0; req1_valid_strobe_i = 1'b0;
      req0_x_i = '0; req0_y_i = '0; req0_z_i = '0;
      req1_x_i = '0; req1_y_i = '0; req1_z_i = '0;
      cordic_x_i = '0; cordic_y_i = '0; cordic_z_i = '0;
      cordic_valid_strobe_i = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("reset_outputs", 64'(all_out), 64'd0);

      // Single-channel jobs from the vector table.
      foreach (vecs[i]) begin
         c0 = n_cordic; r0 = n_res0; r1 = n_res1;
         set_ch(vecs[i].ch, vecs[i].x, vecs[i].y, vecs[i].z);
         pulse();
         check($sformatf("v%0d_busy_set", i), 64'(vecs[i].ch ? req1_busy_o : req0_busy_o), 64'd1);
         wait_for(0, 10, k);
         check($sformatf("v%0d_issue_lat", i), 64'(k), 64'd1);
         check($sformatf("v%0d_ops", i), 64'({cordic_x_o, cordic_y_o, cordic_z_o}),
               64'({vecs[i].x, vecs[i].y, vecs[i].z}));
         wait_for(vecs[i].ch ? 2 : 1, 20, k);
         check($sformatf("v%0d_res_lat", i), 64'(k), 64'd8);
         check($sformatf("v%0d_res", i), 64'({res_x_o, res_y_o, res_z_o}),
               64'({vecs[i].ex, vecs[i].ey, vecs[i].ez}));
         @(negedge clk);
         check($sformatf("v%0d_busy_clr", i), 64'({req0_busy_o, req1_busy_o}), 64'd0);
         check($sformatf("v%0d_res_hold", i), 64'({res_x_o, res_y_o, res_z_o}),
               64'({vecs[i].ex, vecs[i].ey, vecs[i].ez}));
         check($sformatf("v%0d_n_cordic", i), 64'(n_cordic - c0), 64'd1);
         check($sformatf("v%0d_n_res0", i), 64'(n_res0 - r0), 64'(!vecs[i].ch));
         check($sformatf("v%0d_n_res1", i), 64'(n_res1 - r1), 64'(vecs[i].ch));
      end

      // Simultaneous pairs: last grant was ch1, so ch0 wins, then ch0 again next pair.
      set_ch(1'b0, 8'sd21, 8'sd0, 8'sd0); set_ch(1'b1, 8'sd42, 8'sd0, 8'sd0);
      pulse();
      serve("pairA0", 8'sd21, 1'b0);
      serve("pairA1", 8'sd42, 1'b1);
      @(negedge clk);
      set_ch(1'b0, 8'sd50, 8'sd0, 8'sd0); set_ch(1'b1, 8'sd60, 8'sd0, 8'sd0);
      pulse();
      serve("pairB0", 8'sd50, 1'b0);
      serve("pairB1", 8'sd60, 1'b1);
      // Ch0 granted last -> the next pair starts with ch1.
      @(negedge clk);
      set_ch(1'b0, 8'sd1, 8'sd0, 8'sd0);
      pulse();
      serve("solo0", 8'sd1, 1'b0);
      @(negedge clk);
      set_ch(1'b0, 8'sd70, 8'sd0, 8'sd0); set_ch(1'b1, 8'sd80, 8'sd0, 8'sd0);
      pulse();
      serve("pairC1", 8'sd80, 1'b1);
      serve("pairC0", 8'sd70, 1'b0);
      @(negedge clk);

      // Strobes while busy are dropped, including during the clearing cycle.
      set_ch(1'b1, 8'sd5, 8'sd0, 8'sd0);
      pulse();
      set_ch(1'b1, 8'sd9, 8'sd0, 8'sd0);
      pulse();
      check("drop_issue", 64'(cordic_valid_strobe_o), 64'd1);
      check("drop_op", 64'(cordic_x_o), 64'd5);
      wait_for(2, 20, k);
      check("drop_res_lat", 64'(k), 64'd8);
      check("drop_res_x", 64'(res_x_o), 64'd6);
      set_ch(1'b1, 8'sd33, 8'sd0, 8'sd0);
      pulse();
      check("drop_busy_clr", 64'(req1_busy_o), 64'd0);
      c0 = n_cordic; r1 = n_res1;
      repeat (20) @(negedge clk);
      check("drop_no_issue", 64'(n_cordic - c0), 64'd0);
      check("drop_no_res", 64'(n_res1 - r1), 64'd0);

      // Done arriving with the counter at its limit beats the timeout.
      model_lat = T + 1;
      t0 = n_to;
      set_ch(1'b0, 8'sd7, 8'sd0, 8'sd0);
      pulse();
      wait_for(0, 10, k);
      check("late_issue", 64'(k), 64'd1);
      wait_for(1, 30, k);
      check("late_res_lat", 64'(k), 64'(T + 2));
      check("late_res_x", 64'(res_x_o), 64'd8);
      check("late_no_timeout", 64'(n_to - t0), 64'd0);
      @(negedge clk);
      check("late_busy_clr", 64'(req0_busy_o), 64'd0);

      // No done at all: abort T+1 cycles after ISSUE ends.
      model_en = 1'b0;
      model_lat = 7;
      r0 = n_res0; r1 = n_res1;
      set_ch(1'b0, 8'sd3, 8'sd0, 8'sd0);
      pulse();
      wait_for(0, 10, k);
      check("to_issue", 64'(k), 64'd1);
      wait_for(3, 40, k);
      check("to_lat", 64'(k), 64'(T + 2));
      check("to_busy_clr", 64'(req0_busy_o), 64'd0);
      @(negedge clk);
      check("to_one_cycle", 64'(timeout_o), 64'd0);
      check("to_no_res", 64'((n_res0 - r0) + (n_res1 - r1)), 64'd0);
      model_en = 1'b1;
      repeat (2) @(negedge clk);

      // Reset during WAIT; the model's later done must be ignored.
      set_ch(1'b0, 8'sd4, 8'sd0, 8'sd0);
      pulse();
      wait_for(0, 10, k);
      check("rst_issue", 64'(k), 64'd1);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      c0 = n_cordic; r0 = n_res0; r1 = n_res1; t0 = n_to;
      repeat (15) @(negedge clk);
      check("rst_no_res", 64'((n_res0 - r0) + (n_res1 - r1)), 64'd0);
      check("rst_no_timeout", 64'(n_to - t0), 64'd0);
      check("rst_no_issue", 64'(n_cordic - c0), 64'd0);
      check("rst_outputs", 64'(all_out), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got running expected done");
      $fatal(1);
   end

endmodule
